// File: rtl/mux3to1_case_reg_pkg.sv
// Shared select encoding for the registered 3-to-1 multiplexer.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_D0  = 2'b00;
  localparam sel_t SEL_D1  = 2'b01;
  localparam sel_t SEL_D2  = 2'b10;
  localparam sel_t SEL_BAD = 2'b11;

endpackage

// File: rtl/mux3to1_case_comb.sv
// Pure combinational 3-to-1 case decoder; code 2'b11 and unknown selects yield ILLEGAL_VAL.
module mux3to1_case_comb
  import mux_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0
) (
  input  sel_t             i_s,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = ILLEGAL_VAL;
    case (i_s)
      SEL_D0:  o_y = i_d0;
      SEL_D1:  o_y = i_d1;
      SEL_D2:  o_y = i_d2;
      default: o_y = ILLEGAL_VAL;
    endcase
  end

endmodule

// File: rtl/mux3to1_case_reg.sv
// Registered 3-to-1 multiplexer with an illegal-select flag; one clock of latency,
// outputs cleared asynchronously while rst_n is low.
module mux3to1_case_reg
  import mux_pkg::*;
#(
  parameter int               WIDTH       = 3,
  parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sel_t             s,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] y,
  output logic             sel_err
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y;
  logic             r_sel_err;

  mux3to1_case_comb #(
    .WIDTH       (WIDTH),
    .ILLEGAL_VAL (ILLEGAL_VAL)
  ) u_comb (
    .i_s  (s),
    .i_d0 (d0),
    .i_d1 (d1),
    .i_d2 (d2),
    .o_y  (w_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y       <= '0;
      r_sel_err <= 1'b0;
    end else begin
      r_y       <= w_y;
      r_sel_err <= (s == SEL_BAD);
    end
  end

  assign y       = r_y;
  assign sel_err = r_sel_err;

endmodule

// File: tb/tb_mux3to1_case_reg.sv
// Self-checking bench: directed scenarios plus random vectors against an array-indexed model.
module tb_mux3to1_case_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] s = 2'b00;
  logic [2:0] d0 = '0, d1 = '0, d2 = '0;
  logic [2:0] y;
  logic       sel_err;

  logic [1:0] s8 = 2'b00;
  logic [7:0] a8 = '0, b8 = '0, c8 = '0;
  logic [7:0] y8;
  logic       sel_err8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux3to1_case_reg #(.WIDTH(3), .ILLEGAL_VAL(3'b000)) dut (
    .clk(clk), .rst_n(rst_n), .s(s), .d0(d0), .d1(d1), .d2(d2),
    .y(y), .sel_err(sel_err)
  );

  mux3to1_case_reg #(.WIDTH(8), .ILLEGAL_VAL(8'hFF)) dut8 (
    .clk(clk), .rst_n(rst_n), .s(s8), .d0(a8), .d1(b8), .d2(c8),
    .y(y8), .sel_err(sel_err8)
  );

  // Reference: sources as an array, select as an index; anything past the
  // last source is the illegal code.
  function automatic logic [7:0] model(input int sel, input logic [7:0] a,
                                       input logic [7:0] b, input logic [7:0] c,
                                       input logic [7:0] bad);
    logic [7:0] src [3];
    src[0] = a; src[1] = b; src[2] = c;
    return (sel < 3) ? src[sel] : bad;
  endfunction

  task automatic test_reset();
    #2 rst_n = 1'b0;
    s = 2'($urandom); d0 = 3'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
    #1;
    checks++;
    if (y !== 3'b000 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: y=%b sel_err=%b required y=000 sel_err=0", y, sel_err);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #3;
      s = 2'($urandom); d0 = 3'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
      checks++;
      if (y !== 3'b000 || sel_err !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: y=%b sel_err=%b required y=000 sel_err=0", i, y, sel_err);
      end
    end
    @(negedge clk);
    s = 2'b01; d1 = 3'b101;
    rst_n = 1'b1;
    #1;
    checks++;
    if (y !== 3'b000) begin
      errors++;
      $display("FAIL reset_release_early: y=%b required 000", y);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 3'b101 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_capture: y=%b sel_err=%b required y=101 sel_err=0", y, sel_err);
    end
  endtask

  task automatic test_select_sweep();
    int         sv [5];
    logic [2:0] exp_y [5];
    sv[0] = 0; sv[1] = 1; sv[2] = 2; sv[3] = 3; sv[4] = 4;
    exp_y[0] = 3'b000; exp_y[1] = 3'b001; exp_y[2] = 3'b010;
    exp_y[3] = 3'b000; exp_y[4] = 3'b000;
    d0 = 3'b000; d1 = 3'b001; d2 = 3'b010;
    for (int i = 0; i < 5; i++) begin
      s = 2'(sv[i]);
      @(posedge clk); #1;
      checks++;
      if (y !== exp_y[i] || sel_err !== (i == 3)) begin
        errors++;
        $display("FAIL select_sweep s=%0d: y=%b sel_err=%b required y=%b sel_err=%b",
                 sv[i], y, sel_err, exp_y[i], (i == 3));
      end
    end
  endtask

  task automatic test_data_tracking();
    logic [2:0] prev;
    s = 2'b10;
    d2 = 3'b111;
    @(posedge clk); #1;
    prev = 3'b111;
    for (int k = 0; k < 8; k++) begin
      d2 = 3'(k); d0 = 3'($urandom); d1 = 3'($urandom);
      #2;
      checks++;
      if (y !== prev) begin
        errors++;
        $display("FAIL track_hold k=%0d: y=%b required %b", k, y, prev);
      end
      @(posedge clk); #1;
      checks++;
      if (y !== 3'(k) || sel_err !== 1'b0) begin
        errors++;
        $display("FAIL track_capture k=%0d: y=%b sel_err=%b required y=%b sel_err=0", k, y, sel_err, 3'(k));
      end
      prev = 3'(k);
    end
  endtask

  task automatic test_reset_mid();
    s = 2'b01; d1 = 3'b101;
    @(posedge clk); #1;
    checks++;
    if (y !== 3'b101) begin
      errors++;
      $display("FAIL mid_capture: y=%b required 101", y);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (y !== 3'b000 || sel_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_async_clear: y=%b sel_err=%b required y=000 sel_err=0", y, sel_err);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 3'b000) begin
      errors++;
      $display("FAIL mid_hold: y=%b required 000", y);
    end
    d1 = 3'b110;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y !== 3'b110) begin
      errors++;
      $display("FAIL mid_release: y=%b required 110", y);
    end
  endtask

  task automatic test_param();
    s8 = 2'b11; a8 = 8'h12; b8 = 8'h34; c8 = 8'h56;
    @(posedge clk); #1;
    checks++;
    if (y8 !== 8'hFF || sel_err8 !== 1'b1) begin
      errors++;
      $display("FAIL param_illegal: y=%h sel_err=%b required y=ff sel_err=1", y8, sel_err8);
    end
    s8 = 2'b00; a8 = 8'hA5;
    @(posedge clk); #1;
    checks++;
    if (y8 !== 8'hA5 || sel_err8 !== 1'b0) begin
      errors++;
      $display("FAIL param_d0: y=%h sel_err=%b required y=a5 sel_err=0", y8, sel_err8);
    end
  endtask

  task automatic test_random();
    logic [7:0] e3, e8;
    logic       err3, err8;
    int         n_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      s  = 2'($urandom); d0 = 3'($urandom); d1 = 3'($urandom); d2 = 3'($urandom);
      s8 = 2'($urandom); a8 = 8'($urandom); b8 = 8'($urandom); c8 = 8'($urandom);
      e3 = model(int'(s), {5'b0, d0}, {5'b0, d1}, {5'b0, d2}, 8'h00);
      e8 = model(int'(s8), a8, b8, c8, 8'hFF);
      err3 = (int'(s) >= 3);
      err8 = (int'(s8) >= 3);
      @(posedge clk); #1;
      checks++;
      if (y !== e3[2:0] || sel_err !== err3) begin
        errors++;
        if (n_bad < 10)
          $display("FAIL random_w3 #%0d: y=%b sel_err=%b required y=%b sel_err=%b",
                   i, y, sel_err, e3[2:0], err3);
        n_bad++;
      end
      checks++;
      if (y8 !== e8 || sel_err8 !== err8) begin
        errors++;
        if (n_bad < 10)
          $display("FAIL random_w8 #%0d: y=%h sel_err=%b required y=%h sel_err=%b",
                   i, y8, sel_err8, e8, err8);
        n_bad++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_select_sweep();
    test_data_tracking();
    test_reset_mid();
    test_param();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
